// File: rtl/udiv_laccp_pkg.sv
// Shared constants, FSM encoding and latency helper for the fixed-point
// divider with AXI-Stream style handshakes.
package udiv_laccp_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Accept edge to FIFO write edge: operand register, core load, DW+QF steps, fix-up.
    function automatic int udiv_latency(input int dw, input int qf);
        return dw + qf + 2;
    endfunction

endpackage

// File: rtl/udiv_laccp_qr_core.sv
// Restoring shift/subtract divider producing floor(dividend*2^QF/divisor)
// with rounding, saturation and divide-by-zero selection in the FIX state.
module udiv_laccp_qr_core
    import udiv_laccp_pkg::*;
#(
    parameter int DW    = 16,
    parameter int QI    = 16,
    parameter int QF    = 8,
    parameter int ROUND = ROUND_TRUNC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DW-1:0]      dividend,
    input  logic [DW-1:0]      divisor,
    output logic               idle,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow,
    output logic [QI+QF-1:0]   quotient,
    output logic [DW-1:0]      remainder
);

    localparam int NW   = DW + QF;
    localparam int QW   = QI + QF;
    localparam int XW   = ((QW > NW) ? QW : NW) + 1;
    localparam int CNTW = $clog2(NW);

    state_t          state_q, state_d;
    logic [NW-1:0]   num_q;
    logic [DW-1:0]   rem_q;
    logic [CNTW-1:0] cnt_q;

    logic [DW:0]     trial;
    logic            ge;
    logic            last;
    logic            round_up;
    logic [XW-1:0]   q_ext;
    logic            sat;

    // num_q starts as the scaled dividend and fills with quotient bits from the LSB.
    assign trial    = {rem_q, num_q[NW-1]};
    assign ge       = trial >= {1'b0, divisor};
    assign last     = cnt_q == CNTW'(NW - 1);
    assign round_up = (ROUND == ROUND_HALF_UP) && ({rem_q, 1'b0} >= {1'b0, divisor});
    assign q_ext    = XW'(num_q) + XW'(round_up);
    assign sat      = |(q_ext >> QW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_FIX;
            ST_FIX:             state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            num_q <= {dividend, QF'(0)};
            rem_q <= '0;
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            num_q <= {num_q[NW-2:0], ge};
            rem_q <= ge ? (trial[DW-1:0] - divisor) : trial[DW-1:0];
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        idle        = state_q == ST_IDLE;
        done        = state_q == ST_FIX;
        div_by_zero = 1'b0;
        overflow    = 1'b0;
        quotient    = q_ext[QW-1:0];
        remainder   = rem_q;
        if (divisor == '0) begin
            div_by_zero = 1'b1;
            quotient    = '1;
            remainder   = dividend;
        end else if (sat) begin
            overflow    = 1'b1;
            quotient    = '1;
            remainder   = '0;
        end
    end

endmodule

// File: rtl/udiv_qr_laccp_axis.sv
// Stream wrapper: operand capture, start sequencing and a first-word
// fall-through result FIFO around the iterative divider core.
module udiv_qr_laccp_axis
    import udiv_laccp_pkg::*;
#(
    parameter int DW     = 16,
    parameter int QI     = 16,
    parameter int QF     = 8,
    parameter int UW     = 8,
    parameter int ODEPTH = 4,
    parameter int ROUND  = ROUND_TRUNC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DW-1:0]             s_axis_dividend,
    input  logic [DW-1:0]             s_axis_divisor,
    input  logic [UW-1:0]             s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_div_by_zero,
    output logic                      m_axis_overflow,
    output logic [QI-1:0]             m_axis_q_int,
    output logic [QF-1:0]             m_axis_q_frac,
    output logic [DW-1:0]             m_axis_remainder,
    output logic [UW-1:0]             m_axis_tuser,
    output logic [$clog2(ODEPTH):0]   o_fifo_count
);

    localparam int QW = QI + QF;
    localparam int AW = $clog2(ODEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic          dbz;
        logic          ovf;
        logic [QW-1:0] q;
        logic [DW-1:0] rem;
        logic [UW-1:0] tag;
    } entry_t;

    logic          rst_sync;
    logic          start_q;
    logic [DW-1:0] op_dividend, op_divisor;
    logic [UW-1:0] op_tag;

    logic          core_idle, core_done, core_dbz, core_ovf;
    logic [QW-1:0] core_q;
    logic [DW-1:0] core_rem;

    entry_t        mem [ODEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          accept, push, pop;

    // Ready is held off until one edge after reset release, so the release edge cannot accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 1'b0;
        else      rst_sync <= 1'b1;
    end

    assign s_axis_tready = rst_sync && core_idle && !start_q && (count < CW'(ODEPTH));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = core_done;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q     <= 1'b0;
            op_dividend <= '0;
            op_divisor  <= '0;
            op_tag      <= '0;
        end else begin
            start_q <= accept;
            if (accept) begin
                op_dividend <= s_axis_dividend;
                op_divisor  <= s_axis_divisor;
                op_tag      <= s_axis_tuser;
            end
        end
    end

    udiv_laccp_qr_core #(
        .DW    (DW),
        .QI    (QI),
        .QF    (QF),
        .ROUND (ROUND)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start       (start_q),
        .dividend    (op_dividend),
        .divisor     (op_divisor),
        .idle        (core_idle),
        .done        (core_done),
        .div_by_zero (core_dbz),
        .overflow    (core_ovf),
        .quotient    (core_q),
        .remainder   (core_rem)
    );

    // NOTE: FIFO storage has no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{dbz: core_dbz, ovf: core_ovf, q: core_q, rem: core_rem, tag: op_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_axis_tvalid      = count != '0;
    assign head               = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign m_axis_div_by_zero = head.dbz;
    assign m_axis_overflow    = head.ovf;
    assign m_axis_q_int       = head.q[QW-1:QF];
    assign m_axis_q_frac      = head.q[QF-1:0];
    assign m_axis_remainder   = head.rem;
    assign m_axis_tuser       = head.tag;
    assign o_fifo_count       = count;

endmodule

// File: tb/tb_udiv_qr_laccp_axis.sv
// Directed bench: default, ROUND=1 and QI=8 instances run in lockstep on
// shared stimulus; expected values are hand-computed constants.
module tb_udiv_qr_laccp_axis;
    import udiv_laccp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_dividend = '0;
    logic [15:0] s_divisor = '0;
    logic [7:0]  s_tuser = '0;
    logic        m_tready = 1'b0;

    logic        s_tready, m_tvalid, dbz, ovf;
    logic [15:0] qi, rem;
    logic [7:0]  qf, tu;
    logic [2:0]  cnt;

    logic        r_s_tready, r_m_tvalid, r_dbz, r_ovf;
    logic [15:0] r_qi, r_rem;
    logic [7:0]  r_qf, r_tu;
    logic [2:0]  r_cnt;

    logic        q8_s_tready, q8_m_tvalid, q8_dbz, q8_ovf;
    logic [7:0]  q8_qi, q8_qf, q8_tu;
    logic [15:0] q8_rem;
    logic [2:0]  q8_cnt;

    int checks = 0;
    int errors = 0;
    int lat;
    int exp_qi [6] = '{3, 6, 10, 13, 16, 20};
    int exp_qf [6] = '{85, 170, 0, 85, 170, 0};

    always #5 clk = ~clk;

    udiv_qr_laccp_axis #(.ROUND(ROUND_TRUNC)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_dividend(s_dividend), .s_axis_divisor(s_divisor), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_div_by_zero(dbz), .m_axis_overflow(ovf),
        .m_axis_q_int(qi), .m_axis_q_frac(qf), .m_axis_remainder(rem),
        .m_axis_tuser(tu), .o_fifo_count(cnt)
    );

    udiv_qr_laccp_axis #(.ROUND(ROUND_HALF_UP)) dut_r (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(r_s_tready),
        .s_axis_dividend(s_dividend), .s_axis_divisor(s_divisor), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(r_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_div_by_zero(r_dbz), .m_axis_overflow(r_ovf),
        .m_axis_q_int(r_qi), .m_axis_q_frac(r_qf), .m_axis_remainder(r_rem),
        .m_axis_tuser(r_tu), .o_fifo_count(r_cnt)
    );

    udiv_qr_laccp_axis #(.QI(8)) dut_q8 (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(q8_s_tready),
        .s_axis_dividend(s_dividend), .s_axis_divisor(s_divisor), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(q8_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_div_by_zero(q8_dbz), .m_axis_overflow(q8_ovf),
        .m_axis_q_int(q8_qi), .m_axis_q_frac(q8_qf), .m_axis_remainder(q8_rem),
        .m_axis_tuser(q8_tu), .o_fifo_count(q8_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the sample point (#1 after an edge); returns #1 after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
        int n = 0;
        while (!s_tready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("send_ready", 32'(s_tready), 32'd1);
        s_tvalid   = 1'b1;
        s_dividend = a;
        s_divisor  = b;
        s_tuser    = tag;
        @(posedge clk); #1;
        s_tvalid   = 1'b0;
        s_dividend = 16'hDEAD;
        s_divisor  = 16'hBEEF;
        s_tuser    = 8'hEE;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!m_tvalid && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic wait_count(input string tag, input logic [2:0] target);
        int n = 0;
        while (cnt != target && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check(tag, 32'(cnt), 32'(target));
    endtask

    task automatic pop();
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_data", {qi, qf, tu}, 32'd0);
        check("rst_flags_rem", {dbz, ovf, rem}, 32'd0);
        rst = 1'b1;
        #1;
        check("release_no_ready", 32'(s_tready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_release", 32'(s_tready), 32'd1);

        // 100/7 -> 3657 r1 = 14 + 73/256, latency from accept
        send(16'd100, 16'd7, 8'h5A);
        wait_valid(lat);
        check("latency", 32'(lat), 32'(udiv_latency(16, 8)));
        check("div100_7_qint", 32'(qi), 32'd14);
        check("div100_7_qfrac", 32'(qf), 32'd73);
        check("div100_7_rem", 32'(rem), 32'd1);
        check("div100_7_tuser", 32'(tu), 32'h5A);
        check("div100_7_flags", {dbz, ovf}, 32'd0);
        pop();
        check("pop_empty", {m_tvalid, cnt}, 32'd0);

        // 2/3 -> 170 r2; half-up rounds to 171
        send(16'd2, 16'd3, 8'h01);
        wait_valid(lat);
        check("div2_3_trunc", {qi, qf, rem}, {16'd0, 8'd170, 16'd2});
        check("div2_3_round", {r_qi, r_qf, r_rem}, {16'd0, 8'd171, 16'd2});
        pop();

        send(16'd5, 16'd0, 8'h02);
        wait_valid(lat);
        check("div0_flags", {dbz, ovf}, 32'b10);
        check("div0_q", {qi, qf}, 32'hFFFFFF);
        check("div0_rem", 32'(rem), 32'd5);
        pop();

        // 1000/2 -> 128000: fits QI=16 (500.0), saturates QI=8
        send(16'd1000, 16'd2, 8'h03);
        wait_valid(lat);
        check("div1000_2_q16", {ovf, qi, qf}, {1'b0, 16'd500, 8'd0});
        check("div1000_2_q8_ovf", 32'(q8_ovf), 32'd1);
        check("div1000_2_q8_q", {q8_qi, q8_qf}, 32'hFFFF);
        check("div1000_2_q8_rem", 32'(q8_rem), 32'd0);
        pop();

        send(16'hFFFF, 16'd1, 8'h04);
        wait_valid(lat);
        check("divmax_1", {ovf, qi, qf, rem[6:0]}, {1'b0, 16'hFFFF, 8'h00, 7'd0});
        pop();

        // Fill FIFO with tags 1..4; tags 5,6 must wait for space
        for (int i = 1; i <= 4; i++) send(16'(i * 10), 16'd3, 8'(i));
        wait_count("fill_count", 3'd4);
        repeat (30) @(posedge clk);
        #1;
        check("full_no_ready", 32'(s_tready), 32'd0);
        check("full_count", 32'(cnt), 32'd4);
        fork
            begin
                send(16'd50, 16'd3, 8'd5);
                send(16'd60, 16'd3, 8'd6);
            end
            begin
                m_tready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    int n = 0;
                    while (!m_tvalid && n < 200) begin
                        @(posedge clk); #1; n++;
                    end
                    check($sformatf("drain%0d_tag", i), 32'(tu), 32'(i + 1));
                    check($sformatf("drain%0d_q", i), {qi, qf}, {16'(exp_qi[i]), 8'(exp_qf[i])});
                    @(posedge clk); #1;
                end
                m_tready = 1'b0;
            end
        join
        check("drained_count", 32'(cnt), 32'd0);

        // Pop on the exact edge the core writes: count must not change
        for (int i = 0; i < 3; i++) send(16'(8'h11 + i), 16'd1, 8'(8'h11 + i));
        wait_count("pre_coincide_count", 3'd3);
        send(16'h14, 16'd1, 8'h14);
        repeat (25) @(posedge clk);
        #1;
        check("coincide_before", 32'(cnt), 32'd3);
        m_tready = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        check("coincide_count", 32'(cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("coincide_tag%0d", i), {tu, qi}, {8'(8'h12 + i), 16'(16'h12 + i)});
            pop();
        end
        check("coincide_empty", 32'(cnt), 32'd0);

        // Reset mid-run with two results queued
        send(16'd100, 16'd7, 8'h21);
        send(16'd200, 16'd7, 8'h22);
        wait_count("pre_reset_count", 3'd2);
        send(16'd300, 16'd7, 8'h23);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_count", 32'(cnt), 32'd0);
        check("midrst_ready", 32'(s_tready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_tready = 1'b1;
        begin
            int seen = 0;
            repeat (60) begin
                @(posedge clk); #1;
                if (m_tvalid) seen++;
            end
            check("no_stale", 32'(seen), 32'd0);
        end
        m_tready = 1'b0;

        send(16'd100, 16'd7, 8'h5A);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd26);
        check("post_rst_result", {tu, qi, qf}, {8'h5A, 16'd14, 8'd73});
        pop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
